// File: rtl/interval_counter_arbiter_if.sv
// interval_counter_arbiter_if: request/start/abort bundle and result signals shared between requesters and the arbiter
interface interval_counter_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]         req_in;
  logic [N_REQ*WIDTH-1:0]   start_in;
  logic                     abort_in;
  logic [N_REQ-1:0]         grant_out;
  logic [N_REQ-1:0]         done_out;
  logic                     aborted_out;
  logic                     busy_out;
  logic [$clog2(N_REQ)-1:0] owner_out;
  logic [WIDTH-1:0]         count_out;
  modport master (
    output req_in, start_in, abort_in,
    input  grant_out, done_out, aborted_out, busy_out, owner_out, count_out
  );
  modport slave (
    input  req_in, start_in, abort_in,
    output grant_out, done_out, aborted_out, busy_out, owner_out, count_out
  );
endinterface

// File: rtl/interval_counter_arbiter.sv
// interval_counter_arbiter: round-robin sharing of one loadable up-counter that runs each owner's interval to TERM
module interval_counter_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int TERM  = 46
) (
  input logic clk,
  input logic reset_al_in,
  interval_counter_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [IW-1:0]    owner_q, owner_d, last_q, last_d, win, idx;
  logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic             aborted_q, aborted_d;
  // descending scan so the requester closest after last_q is the final assignment
  always_comb begin
    win = last_q;
    idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IW'((int'(last_q) + i) % N_REQ);
      if (bus.req_in[idx]) win = idx;
    end
  end
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    owner_d   = owner_q;
    last_d    = last_q;
    grant_d   = '0;
    done_d    = '0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: if (|bus.req_in) begin
        state_d = RUN;
        owner_d = win;
        last_d  = win;
        count_d = bus.start_in[win*WIDTH +: WIDTH];
        grant_d = N_REQ'(1) << win;
      end
      RUN: if (bus.abort_in || count_q >= WIDTH'(TERM)) begin
        state_d   = DONE;
        count_d   = '0;
        done_d    = N_REQ'(1) << owner_q;
        aborted_d = bus.abort_in;
      end else count_d = count_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_al_in)
    if (!reset_al_in) begin
      state_q   <= IDLE;
      count_q   <= '0;
      owner_q   <= '0;
      last_q    <= IW'(N_REQ - 1);
      grant_q   <= '0;
      done_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  assign bus.grant_out   = grant_q;
  assign bus.done_out    = done_q;
  assign bus.aborted_out = aborted_q;
  assign bus.busy_out    = state_q != IDLE;
  assign bus.owner_out   = owner_q;
  assign bus.count_out   = count_q;
endmodule

// File: tb/tb_interval_counter_arbiter.sv
// tb_interval_counter_arbiter: vector table, corner-case sequences and a randomized run against an interval-level model
module tb_interval_counter_arbiter;
  localparam int W = 8, N = 4, TERM = 46;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_cmp = 0, n_bad = 0;
  interval_counter_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus ();
  interval_counter_arbiter #(.WIDTH(W), .N_REQ(N), .TERM(TERM)) dut (.clk(clk), .reset_al_in(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] st;
    logic         ab;
    logic [N-1:0] g, d;
    logic         a, b;
    logic [W-1:0] c;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(input int r, input int s, input int ab, input int g, input int d, input int a, input int b, input int c);
    tbl.push_back('{N'(r), W'(s), 1'(ab), N'(g), N'(d), 1'(a), 1'(b), W'(c)});
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [N-1:0] r, input logic [W-1:0] s, input logic ab);
    bus.req_in   = r;
    bus.start_in = {N{s}};
    bus.abort_in = ab;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, ".grant"}, bus.grant_out, 0);
    chk({tag, ".done"}, bus.done_out, 0);
    chk({tag, ".aborted"}, bus.aborted_out, 0);
    chk({tag, ".busy"}, bus.busy_out, 0);
    chk({tag, ".owner"}, bus.owner_out, 0);
    chk({tag, ".count"}, bus.count_out, 0);
  endtask
  task automatic do_reset;
    drive('0, '0, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    check_zero("reset");
    rst_n = 1'b1;
  endtask
  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction
  task automatic wait_idle(input string tag);
    int k = 0;
    while (bus.busy_out && k < 100) begin
      tick();
      k++;
    end
    if (k == 100) chk({tag, ".idle_timeout"}, 1, 0);
  endtask
  // result cycles of grants/dones for a held request pattern; drop=1 means a requester releases after its grant
  task automatic run_share(input string tag, input logic [N-1:0] r0, input logic drop, input int exp_owner[4]);
    int gc[$], go[$], dc[$];
    logic [N-1:0] r = r0;
    drive(r, 8'd44, 1'b0);
    for (int cyc = 0; cyc < 200 && dc.size() < 4; cyc++) begin
      tick();
      if (bus.grant_out != 0) begin
        gc.push_back(cyc);
        go.push_back(oh_idx(bus.grant_out));
        chk({tag, ".owner_at_grant"}, bus.owner_out, oh_idx(bus.grant_out));
        if (drop) r &= ~bus.grant_out;
        if (gc.size() == 4) r = '0;
        drive(r, 8'd44, 1'b0);
      end
      if (bus.done_out != 0) begin
        dc.push_back(cyc);
        chk({tag, ".grant_done_overlap"}, bus.grant_out & bus.done_out, 0);
      end
    end
    chk({tag, ".num_done"}, dc.size(), 4);
    for (int k = 0; k < gc.size() && k < dc.size(); k++) begin
      chk({tag, ".order"}, go[k], exp_owner[k]);
      chk({tag, ".interval"}, dc[k] - gc[k], TERM - 44 + 1);
      if (k > 0) chk({tag, ".gap"}, gc[k] - dc[k-1], 2);
    end
    drive('0, '0, 1'b0);
    wait_idle(tag);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [N-1:0] r, e_g, e_d;
    logic [W-1:0] s[N];
    logic ab, e_a;
    int m_busy, m_ending, m_owner, m_last, m_start, m_t, m_end, e_c, w, k;
    drive('0, '0, 1'b0);
    #2;
    do_reset();
    add(1, 40, 0, 1, 0, 0, 1, 40);
    for (int i = 1; i <= 6; i++) add(0, 40, 0, 0, 0, 0, 1, 40 + i);
    add(0, 40, 0, 0, 1, 0, 1, 0);
    add(0, 40, 0, 0, 0, 0, 0, 0);
    add(1, 200, 0, 1, 0, 0, 1, 200);
    add(0, 200, 0, 0, 1, 0, 1, 0);
    add(0, 200, 0, 0, 0, 0, 0, 0);
    add(1, 40, 0, 1, 0, 0, 1, 40);
    for (int i = 1; i <= 3; i++) add(0, 40, 0, 0, 0, 0, 1, 40 + i);
    add(0, 40, 1, 0, 1, 1, 1, 0);
    add(0, 40, 0, 0, 0, 0, 0, 0);
    add(1, 40, 0, 1, 0, 0, 1, 40);
    for (int i = 1; i <= 6; i++) add(0, 40, 0, 0, 0, 0, 1, 40 + i);
    add(0, 40, 1, 0, 1, 1, 1, 0);
    add(0, 40, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].req, tbl[i].st, tbl[i].ab);
      tick();
      chk($sformatf("vec%0d.grant", i), bus.grant_out, tbl[i].g);
      chk($sformatf("vec%0d.done", i), bus.done_out, tbl[i].d);
      chk($sformatf("vec%0d.aborted", i), bus.aborted_out, tbl[i].a);
      chk($sformatf("vec%0d.busy", i), bus.busy_out, tbl[i].b);
      chk($sformatf("vec%0d.count", i), bus.count_out, tbl[i].c);
      if (tbl[i].b) chk($sformatf("vec%0d.owner", i), bus.owner_out, 0);
    end
    do_reset();
    run_share("contention", 4'b1111, 1'b1, '{0, 1, 2, 3});
    run_share("fairness", 4'b0110, 1'b0, '{1, 2, 1, 2});
    drive(4'b0001, 8'd40, 1'b0);
    tick();
    drive('0, 8'd40, 1'b0);
    k = 0;
    while (bus.count_out != 42 && k < 20) begin
      tick();
      k++;
    end
    chk("midreset.reach42", bus.count_out, 42);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset.async");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midreset.no_done", bus.done_out, 0);
    end
    rst_n = 1'b1;
    drive(4'b1010, 8'd40, 1'b0);
    tick();
    chk("midreset.first_grant", bus.grant_out, 4'b0010);
    chk("midreset.first_owner", bus.owner_out, 1);
    drive('0, '0, 1'b0);
    wait_idle("midreset");
    do_reset();
    r = '0;
    m_busy = 0; m_ending = 0; m_owner = 0; m_last = N - 1; m_start = 0; m_t = 0; m_end = 0; e_c = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!r[i] && $urandom_range(3) == 0) r[i] = 1'b1;
        s[i] = ($urandom_range(9) == 0) ? W'(200 + $urandom_range(55)) : W'(TERM - 8 + $urandom_range(10));
        bus.start_in[i*W +: W] = s[i];
      end
      ab = ($urandom_range(19) == 0);
      bus.req_in = r;
      bus.abort_in = ab;
      @(posedge clk);
      e_g = '0; e_d = '0; e_a = 1'b0;
      if (!m_busy) begin
        if (r != 0) begin
          w = -1;
          for (int o = 1; o <= N && w < 0; o++) if (r[(m_last + o) % N]) w = (m_last + o) % N;
          m_busy = 1; m_ending = 0; m_owner = w; m_last = w; m_start = s[w]; m_t = 0;
          m_end = (m_start >= TERM) ? 1 : TERM - m_start + 1;
          e_g = N'(1) << w;
          e_c = m_start;
        end else e_c = 0;
      end else if (m_ending) begin
        m_busy = 0;
        e_c = 0;
      end else begin
        m_t++;
        if (ab || m_t == m_end) begin
          e_d = N'(1) << m_owner;
          e_a = ab;
          e_c = 0;
          m_ending = 1;
        end else e_c = m_start + m_t;
      end
      #1;
      chk("rand.grant", bus.grant_out, e_g);
      chk("rand.done", bus.done_out, e_d);
      chk("rand.aborted", bus.aborted_out, e_a);
      chk("rand.busy", bus.busy_out, m_busy);
      chk("rand.count", bus.count_out, e_c);
      if (m_busy != 0) chk("rand.owner", bus.owner_out, m_owner);
      r &= ~e_g;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/interval_counter_arbiter.md
# interval_counter_arbiter

Shares one loadable up-counter with a fixed terminal value among N_REQ requesters that each need a timed interval. Round-robin arbitration grants the counter to one requester, loads that requester's start value, counts up to TERM and pulses a one-hot done back to the owner. It is the sequencing and sharing layer for the synchronous loadable/modulus counters in the counters library.

## Interface
- WIDTH, 8, counter and start-value width.
- N_REQ, 4, number of requesters (2..8).
- TERM, 46, terminal count; must satisfy TERM <= 2^WIDTH-1.
- clk  in  1  single clock, rising edge.
- reset_al_in  in  1  reset; asynchronous, active-low.
- req_in  in  N_REQ  level requests; requester deasserts after its grant.
- start_in  in  N_REQ*WIDTH  packed start values; requester i at bits [i*WIDTH +: WIDTH].
- abort_in  in  1  terminates the running interval.
- grant_out  out  N_REQ  one-hot, one-cycle pulse on load.
- done_out  out  N_REQ  one-hot, one-cycle pulse at end of interval.
- aborted_out  out  1  high with done_out when the interval ended by abort.
- busy_out  out  1  high whenever state != IDLE.
- owner_out  out  clog2(N_REQ)  index of current owner; valid while busy_out=1.
- count_out  out  WIDTH  current counter value.

## Operation
- The FSM has three states: IDLE, RUN and DONE. All outputs are registered, or are decoded from registered state only.
- IDLE:
  - If any req_in bit is set at the edge, pick the winner by round-robin, searching from last_owner+1 upward modulo N_REQ.
  - On that edge: owner <= winner; last_owner <= winner; count <= start_in[winner]; grant_out[winner] <= 1; go to RUN.
  - With no request, stay in IDLE with count held at 0.
- RUN:
  - If abort_in=1: count <= 0; done_out[owner] <= 1; aborted_out <= 1; go to DONE.
  - Else if count >= TERM: count <= 0; done_out[owner] <= 1; go to DONE.
  - Else: count <= count+1.
  - req_in is ignored in this state.
- DONE: clear done_out and aborted_out, then go to IDLE unconditionally. Arbitration is not evaluated in this state.
- A start value >= TERM is legal. The counter loads that value, and the next edge ends the interval with no counting. The counter never exceeds max(start, TERM), so it cannot overflow.
- abort_in is ignored in IDLE and DONE. If abort_in and count >= TERM occur on the same edge, abort wins and aborted_out=1.
- A requester that still holds req_in after its done competes normally. Round-robin order guarantees every other pending requester is served first.
- Reset values: state IDLE, count_out 0, grant_out 0, done_out 0, aborted_out 0, busy_out 0, owner_out 0, last_owner N_REQ-1 (requester 0 has first priority).
- Reset asserted mid-RUN or mid-DONE forces all outputs to their reset values immediately. No done pulse is produced and the interval is lost.

## Timing
- Grant latency: a request sampled at IDLE edge k gives grant_out and count_out=start in the cycle after edge k.
- Interval: count_out steps start, start+1, …, TERM, one value per cycle. done_out is high in the cycle after edge k+(TERM-start)+1, with count_out=0. For start >= TERM it is edge k+1.
- busy_out rises with grant_out. It falls one cycle after done_out, when the FSM returns to IDLE.
- Back-to-back turnaround: the earliest next grant is at the edge after returning to IDLE. That gives a 2-cycle gap between a done_out pulse and the next grant_out pulse.
- grant_out and done_out are never high in the same cycle.

## Test plan
- Single interval (TERM=46): reset; req_in=0001 with start 40 → grant_out=0001 for one cycle; count_out 40..46; done_out=0001 with count_out=0 seven edges after the grant edge; busy_out low one cycle later.
- Contention: req_in=1111, each start 44, each requester drops its req after its grant → grants in order 0,1,2,3; each done_out precedes the next grant by 2 cycles.
- Out-of-range start: start 200 → grant with count_out=200 for one cycle, then done_out with count_out=0, aborted_out=0.
- Abort: start 40, abort_in pulsed while count_out=43 → next cycle done_out pulse, aborted_out=1, count_out=0. Same test with abort coinciding with count_out=46 → aborted_out=1.
- Reset mid-interval: assert reset_al_in at count_out=42 → all outputs 0 asynchronously, no done_out pulse. After release, req_in=1010 → requester 1 granted first.
- Fairness: req1 and req2 held continuously → owner_out alternates 1,2,1,2; idle gap of 2 cycles between each done and the next grant.
